// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch stage.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int FETCH_WIDTH = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory, redirect and decode-side signals of the fetch stage.
interface fetch_if #(
    parameter int ADDR_WIDTH = 10
);

    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_instr0;
    logic [31:0]           imem_instr1;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  out_valid0;
    logic                  out_valid1;
    logic [31:0]           out_instr0;
    logic [31:0]           out_instr1;
    logic [31:0]           out_pc0;
    logic [31:0]           out_pc1;
    logic [1:0]            deq_count;

    modport master (
        output imem_addr,
        input  imem_instr0,
        input  imem_instr1,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid0,
        output out_valid1,
        output out_instr0,
        output out_instr1,
        output out_pc0,
        output out_pc1,
        input  deq_count
    );

    modport slave (
        input  imem_addr,
        output imem_instr0,
        output imem_instr1,
        output redirect_valid,
        output redirect_pc,
        input  out_valid0,
        input  out_valid1,
        input  out_instr0,
        input  out_instr1,
        input  out_pc0,
        input  out_pc1,
        output deq_count
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue accepting up to two entries and releasing up to two per cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [1:0]    push_count,
    input  fetch_entry_t  push_data0,
    input  fetch_entry_t  push_data1,
    input  logic [1:0]    pop_count,
    output fetch_entry_t  head_data0,
    output fetch_entry_t  head_data1,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // Storage needs no reset: validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push_count != 2'd0) begin
            mem[tail] <= push_data0;
        end
        if (push_count == 2'd2) begin
            mem[tail + PW'(1)] <= push_data1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_count);
            tail  <= tail + PW'(push_count);
            count <= count + CW'(push_count) - CW'(pop_count);
        end
    end

    assign head_data0 = mem[head];
    assign head_data1 = mem[head + PW'(1)];

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch stage: owns the PC, decides how many returned words to enqueue,
// and handles back-end redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input logic     clk,
    input logic     rst_n,
    fetch_if.master bus
);

    localparam int          CW        = $clog2(QUEUE_DEPTH + 1);
    localparam logic [31:0] STEP_ONE  = 32'(INSTR_BYTES);
    localparam logic [31:0] STEP_PAIR = 32'(FETCH_WIDTH * INSTR_BYTES);

    logic [31:0]   pc;
    logic [31:0]   pc_next;
    logic [31:0]   redirect_target;
    logic [CW-1:0] count;
    logic [CW-1:0] deq_req;
    logic [CW-1:0] deq_eff;
    logic [CW:0]   free;
    logic [1:0]    push_count;
    logic [1:0]    pop_count;
    logic          at_top;
    logic          flush;
    fetch_entry_t  push_data0;
    fetch_entry_t  push_data1;
    fetch_entry_t  head_data0;
    fetch_entry_t  head_data1;

    assign bus.imem_addr   = pc[ADDR_WIDTH+1:2];
    assign at_top          = &bus.imem_addr;
    assign redirect_target = bus.redirect_pc & ~32'h3;

    // Slots released by decode this cycle are reusable by this cycle's fetch.
    assign deq_req = CW'(bus.deq_count);
    assign deq_eff = (deq_req > count) ? count : deq_req;
    assign free    = (CW+1)'(QUEUE_DEPTH) - {1'b0, count} + {1'b0, deq_eff};

    assign push_data0 = '{instr: bus.imem_instr0, pc: pc};
    assign push_data1 = '{instr: bus.imem_instr1, pc: pc + STEP_ONE};

    // The top word is fetched alone so a pair never straddles the address wrap.
    always_comb begin
        flush      = bus.redirect_valid;
        push_count = 2'd0;
        pop_count  = deq_eff[1:0];
        pc_next    = pc;
        if (bus.redirect_valid) begin
            pop_count = 2'd0;
            pc_next   = redirect_target;
        end else if (at_top) begin
            if (free >= (CW+1)'(1)) begin
                push_count = 2'd1;
                pc_next    = pc + STEP_ONE;
            end
        end else if (free >= (CW+1)'(2)) begin
            push_count = 2'd2;
            pc_next    = pc + STEP_PAIR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push_count (push_count),
        .push_data0 (push_data0),
        .push_data1 (push_data1),
        .pop_count  (pop_count),
        .head_data0 (head_data0),
        .head_data1 (head_data1),
        .count      (count)
    );

    assign bus.out_valid0 = (count >= CW'(1));
    assign bus.out_valid1 = (count >= CW'(2));
    assign bus.out_instr0 = head_data0.instr;
    assign bus.out_pc0    = head_data0.pc;
    assign bus.out_instr1 = head_data1.instr;
    assign bus.out_pc1    = head_data1.pc;

    // Decode must never consume more than is presented.
    deq_legal: assert property (@(posedge clk) disable iff (!rst_n)
        !bus.redirect_valid |-> ((deq_req <= count) && (bus.deq_count != 2'd3)));

endmodule
